// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized serial input, mid-bit sampling,
// optional even/odd parity check and stop-bit (framing) check.
// A completed frame is reported with a one-cycle o_valid pulse; data and
// error flags hold until the next frame completes.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);
  localparam logic          ODD_PAR   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [2:0]           idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 perr_reg, perr_next;
  logic                 deliver;

  logic rx_meta, rx_sync, rx_prev;
  logic rx_fall;

  // Synchronizer plus one history flop for start-edge detection; resets to
  // the idle (high) level so a fresh falling edge is needed after reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // A start edge needs the line to have been seen high first, which also
  // keeps a held-low break from retriggering a frame.
  assign rx_fall = rx_prev & ~rx_sync;

  // FSM and datapath state registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      perr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      perr_reg  <= perr_next;
    end
  end

  // Next-state logic: one bit-timing counter drives every mid-bit sample;
  // line activity between scheduled samples is ignored.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    idx_next   = idx_reg;
    shift_next = shift_reg;
    perr_next  = perr_reg;
    deliver    = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (rx_fall) begin
          state_next = START;
          idx_next   = '0;
          perr_next  = 1'b0;
        end
      end

      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          // A start bit that is high again at mid-bit was only a glitch.
          state_next = rx_sync ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt_reg == FULL_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_sync, shift_reg[DATA_BITS-1:1]};
          if (idx_reg == IDX_LAST) begin
            idx_next   = '0;
            state_next = HAS_PAR ? PARITY : STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end

      PARITY: begin
        if (cnt_reg == FULL_LAST) begin
          cnt_next   = '0;
          perr_next  = (^shift_reg) ^ rx_sync ^ ODD_PAR;
          state_next = STOP;
        end
      end

      STOP: begin
        if (cnt_reg == FULL_LAST) begin
          // Returning to IDLE right away lets a back-to-back start edge
          // be caught in the very next cycle.
          cnt_next   = '0;
          deliver    = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output registers: loaded only when a frame completes, held otherwise.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_valid <= deliver;
      if (deliver) begin
        o_data       <= shift_reg;
        o_frame_err  <= ~rx_sync;
        o_parity_err <= HAS_PAR & perr_reg;
      end
    end
  end

  assign o_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: fixed vector table, hand-written corner sequences
// (glitch, reset mid-frame) and random frames checked against a parity /
// framing model computed from bit counts.
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int DB      = 8;
  localparam int PEN     = 1;
  localparam int PODD    = 0;
  localparam int LAT_MAX = ((3 + 2 * DB + 2 * PEN) * CPB) / 2 + 4;

  logic          i_clk   = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_rx    = 1'b1;
  logic [DB-1:0] o_data;
  logic          o_valid;
  logic          o_parity_err;
  logic          o_frame_err;
  logic          o_busy;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .PARITY_EN   (PEN),
    .PARITY_ODD  (PODD)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_parity_err(o_parity_err),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [DB-1:0] data;
    logic          perr;
    logic          ferr;
    int            cyc;
  } obs_t;

  obs_t obs_q[$];

  // Capture every o_valid cycle; a pulse longer than one cycle shows up as
  // an extra entry.
  always @(negedge i_clk) begin
    obs_t o;
    if (o_valid) begin
      o.data = o_data;
      o.perr = o_parity_err;
      o.ferr = o_frame_err;
      o.cyc  = cyc;
      obs_q.push_back(o);
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int start_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: parity error means the total count of ones over data
  // plus parity bit has the wrong oddness.
  function automatic logic ref_perr(input logic [DB-1:0] d, input logic p);
    int ones;
    ones = $countones(d) + int'(p);
    return (PODD == 0) ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  function automatic logic good_par(input logic [DB-1:0] d);
    return ((($countones(d) % 2) == 1) ? 1'b1 : 1'b0) ^ (PODD != 0);
  endfunction

  task automatic drive_bit(input logic b);
    i_rx = b;
    repeat (CPB) @(negedge i_clk);
  endtask

  // Called at a negedge; leaves the line at the stop-bit level.
  task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic s);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PEN != 0) drive_bit(p);
    drive_bit(s);
  endtask

  task automatic check_frame(input string tag, input logic [DB-1:0] ed,
                             input logic epe, input logic efe);
    obs_t o;
    chk({tag, ".valid_count"}, obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      chk({tag, ".data"}, o.data, ed);
      chk({tag, ".parity_err"}, o.perr, epe);
      chk({tag, ".frame_err"}, o.ferr, efe);
      chk({tag, ".latency_ok"}, ((o.cyc - start_cyc) <= LAT_MAX) ? 1 : 0, 1);
    end
    obs_q.delete();
  endtask

  typedef struct {
    logic [DB-1:0] data;
    logic          par;
    logic          stop;
    int            hold_low;
    int            gap;
    logic [DB-1:0] exp_data;
    logic          exp_perr;
    logic          exp_ferr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [DB-1:0] d;
    logic          p, s;
    int            gap, k;

    tbl[0] = '{8'hA5, 1'b0, 1'b1, 0,  10, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h01, 1'b0, 1'b1, 0,  10, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, 40, 20, 8'h3C, 1'b0, 1'b1};
    tbl[3] = '{8'h55, 1'b0, 1'b1, 0,  0,  8'h55, 1'b0, 1'b0};
    tbl[4] = '{8'hAA, 1'b0, 1'b1, 0,  10, 8'hAA, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 1'b1, 1'b1, 0,  5,  8'h00, 1'b1, 1'b0};
    tbl[6] = '{8'h7F, 1'b1, 1'b1, 0,  5,  8'h7F, 1'b0, 1'b0};
    tbl[7] = '{8'h80, 1'b0, 1'b1, 0,  5,  8'h80, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("reset.data", o_data, 0);
    chk("reset.valid", o_valid, 0);
    chk("reset.parity_err", o_parity_err, 0);
    chk("reset.frame_err", o_frame_err, 0);
    chk("reset.busy", o_busy, 0);
    i_reset = 1'b0;
    repeat (10) @(negedge i_clk);

    // Vector table (entry 2 is a break, entries 3/4 are back-to-back)
    for (int v = 0; v < 8; v++) begin
      send_frame(tbl[v].data, tbl[v].par, tbl[v].stop);
      check_frame($sformatf("tbl%0d", v), tbl[v].exp_data, tbl[v].exp_perr, tbl[v].exp_ferr);
      if (tbl[v].hold_low > 0) begin
        i_rx = 1'b0;
        repeat (tbl[v].hold_low) @(negedge i_clk);
      end
      i_rx = 1'b1;
      repeat (tbl[v].gap) @(negedge i_clk);
      chk($sformatf("tbl%0d.quiet", v), obs_q.size(), 0);
    end
    chk("hold.data", o_data, 8'h80);
    chk("hold.parity_err", o_parity_err, 1);

    // Short low glitch: START must reject it
    i_rx = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rx = 1'b1;
    chk("glitch.busy_high", o_busy, 1);
    k = 0;
    while (o_busy && k < 12) begin
      @(negedge i_clk);
      k++;
    end
    chk("glitch.busy_low", o_busy, 0);
    repeat (200) @(negedge i_clk);
    chk("glitch.no_valid", obs_q.size(), 0);
    chk("glitch.data_hold", o_data, 8'h80);

    // Reset during data bit 3 of an 0xFF frame
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    i_rx = 1'b1;
    repeat (8) @(negedge i_clk);
    chk("rst_mid.busy_before", o_busy, 1);
    i_reset = 1'b1;
    #1;
    chk("rst_mid.data", o_data, 0);
    chk("rst_mid.valid", o_valid, 0);
    chk("rst_mid.parity_err", o_parity_err, 0);
    chk("rst_mid.frame_err", o_frame_err, 0);
    chk("rst_mid.busy", o_busy, 0);
    repeat (5) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (200) @(negedge i_clk);
    chk("rst_mid.no_valid", obs_q.size(), 0);
    send_frame(8'h5A, 1'b0, 1'b1);
    check_frame("after_rst", 8'h5A, 1'b0, 1'b0);
    i_rx = 1'b1;
    repeat (5) @(negedge i_clk);

    // Random frames against the reference model
    for (int r = 0; r < 30; r++) begin
      d   = DB'($urandom_range(0, (1 << DB) - 1));
      p   = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
      s   = ($urandom_range(0, 5) != 0);
      gap = $urandom_range(0, 12);
      if (!s && gap < 2) gap = 2;
      send_frame(d, p, s);
      check_frame($sformatf("rnd%0d", r), d, ref_perr(d, p), ~s);
      i_rx = 1'b1;
      repeat (gap) @(negedge i_clk);
    end

    repeat (300) @(negedge i_clk);
    chk("final.quiet", obs_q.size(), 0);
    chk("final.busy", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
